// File: rtl/pattern_generator.sv
// pattern_generator
//   Upstream stage of the score calculator. Steps a 16-bit Galois LFSR on
//   every 10 Hz tick and shows a non-zero 8-bit target pattern for a hold
//   window, followed by a blank gap of 8'h00. The hold window shrinks once
//   per level, and the game ends after NUM_ROUNDS patterns. A correct copy
//   of the pattern on the switches ends the hold window early.
//
// Ports
//   counter10h  in   1  10 Hz tick; every state change happens on its rising edge
//   reset       in   1  asynchronous, active-high
//   start       in   1  level; starts or restarts a game from IDLE or DONE
//   user_input  in   8  player switches
//   pattern     out  8  current target, 8'h00 when nothing is shown
//   round_num   out  8  1-based current/last round, 0 in IDLE
//   level       out  4  0-based level, saturates at 15
//   busy        out  1  high while showing or blanking
//   game_over   out  1  high once all rounds are played
module pattern_generator #(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          START_HOLD   = 20,
  parameter int          MIN_HOLD     = 5,
  parameter int          HOLD_STEP    = 1,
  parameter int          LEVEL_ROUNDS = 4,
  parameter int          GAP_TICKS    = 3,
  parameter int          NUM_ROUNDS   = 32
) (
  input  logic       counter10h,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] user_input,
  output logic [7:0] pattern,
  output logic [7:0] round_num,
  output logic [3:0] level,
  output logic       busy,
  output logic       game_over
);

  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [15:0] SEED_INIT   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0]  HOLD_INIT   = 8'(START_HOLD);
  localparam logic [7:0]  HOLD_MIN    = 8'(MIN_HOLD);
  localparam logic [7:0]  GAP_LAST    = 8'(GAP_TICKS - 1);
  localparam logic [7:0]  ROUNDS_LAST = 8'(NUM_ROUNDS);
  localparam logic [7:0]  LVL_ROUNDS  = 8'(LEVEL_ROUNDS);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK, DONE} state_t;

  state_t      state, state_n;
  logic [15:0] lfsr;
  logic [7:0]  prev, prev_n;
  logic [7:0]  hold, hold_n;
  logic [7:0]  timer, timer_n;
  logic [7:0]  pattern_n, round_n;
  logic [3:0]  level_n;
  logic [7:0]  cand;
  logic        level_up;
  logic [7:0]  hold_next_lvl;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Non-zero candidate that never repeats the previous pattern.
  function automatic logic [7:0] pick_pattern(input logic [7:0] c, input logic [7:0] last);
    logic [7:0] c1;
    c1 = (c == 8'h00) ? 8'h01 : c;
    if (c1 == last) begin
      c1 = c1 + 8'd1;
      if (c1 == 8'h00)
        c1 = 8'h01;
    end
    return c1;
  endfunction

  // Difference is taken in a wider signed domain, so the floor is applied
  // before any wrap can occur.
  function automatic logic [7:0] sat_hold(input logic [7:0] h);
    logic signed [9:0] diff;
    diff = $signed({2'b00, h}) - $signed(10'(HOLD_STEP));
    return (diff < $signed({2'b00, HOLD_MIN})) ? HOLD_MIN : diff[7:0];
  endfunction

  function automatic logic [3:0] sat_level(input logic [3:0] l);
    return (l == 4'hF) ? l : l + 4'd1;
  endfunction

  assign cand          = pick_pattern(lfsr[7:0], prev);
  assign level_up      = ((round_num % LVL_ROUNDS) == 8'd0);
  assign hold_next_lvl = level_up ? sat_hold(hold) : hold;

  always_comb begin
    state_n   = state;
    pattern_n = pattern;
    prev_n    = prev;
    round_n   = round_num;
    level_n   = level;
    hold_n    = hold;
    timer_n   = timer;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = SHOW;
          pattern_n = cand;
          prev_n    = cand;
          round_n   = 8'd1;
          level_n   = 4'd0;
          hold_n    = HOLD_INIT;
          timer_n   = HOLD_INIT - 8'd1;
        end
      end
      SHOW: begin
        if ((user_input == pattern) || (timer == 8'd0)) begin
          state_n   = BLANK;
          pattern_n = 8'h00;
          timer_n   = GAP_LAST;
        end else begin
          timer_n = timer - 8'd1;
        end
      end
      BLANK: begin
        if (timer != 8'd0) begin
          timer_n = timer - 8'd1;
        end else if (round_num == ROUNDS_LAST) begin
          state_n = DONE;
        end else begin
          state_n   = SHOW;
          round_n   = round_num + 8'd1;
          level_n   = level_up ? sat_level(level) : level;
          hold_n    = hold_next_lvl;
          timer_n   = hold_next_lvl - 8'd1;
          pattern_n = cand;
          prev_n    = cand;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered state and outputs, advanced on each tick
  always_ff @(posedge counter10h or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= SEED_INIT;
      pattern   <= 8'h00;
      prev      <= 8'h00;
      round_num <= 8'd0;
      level     <= 4'd0;
      hold      <= HOLD_INIT;
      timer     <= 8'd0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_step(lfsr);
      pattern   <= pattern_n;
      prev      <= prev_n;
      round_num <= round_n;
      level     <= level_n;
      hold      <= hold_n;
      timer     <= timer_n;
      busy      <= (state_n == SHOW) || (state_n == BLANK);
      game_over <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_pattern_generator.sv
// tb_pattern_generator
//   Directed bench for pattern_generator. Several instances with different
//   parameter sets share one tick clock and reset; each phase resets all of
//   them and drives only the start/user_input of the instance it exercises.
//   Expected LFSR-derived patterns are hand-computed from the seeds.
module tb_pattern_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, start_b, start_c;
  logic [7:0] ui_a, ui_b, ui_c;

  logic [7:0] pat_a, rnd_a;
  logic [3:0] lvl_a;
  logic       busy_a, go_a;

  logic [7:0] pat_b, rnd_b;
  logic [3:0] lvl_b;
  logic       busy_b, go_b;

  logic [7:0] pat_c [4];
  logic [7:0] rnd_c [4];
  logic [3:0] lvl_c [4];
  logic       busy_c [4];
  logic       go_c [4];

  int total = 0;
  int bad   = 0;

  pattern_generator #(.START_HOLD(4), .GAP_TICKS(2), .NUM_ROUNDS(2)) dut_a (
    .counter10h(clk), .reset(reset), .start(start_a), .user_input(ui_a),
    .pattern(pat_a), .round_num(rnd_a), .level(lvl_a), .busy(busy_a), .game_over(go_a));

  pattern_generator #(.START_HOLD(6), .MIN_HOLD(4), .HOLD_STEP(1), .LEVEL_ROUNDS(2),
                      .NUM_ROUNDS(8)) dut_b (
    .counter10h(clk), .reset(reset), .start(start_b), .user_input(ui_b),
    .pattern(pat_b), .round_num(rnd_b), .level(lvl_b), .busy(busy_b), .game_over(go_b));

  pattern_generator #(.LFSR_SEED(16'h0155), .START_HOLD(1), .MIN_HOLD(1), .GAP_TICKS(1),
                      .NUM_ROUNDS(2)) dut_c0 (
    .counter10h(clk), .reset(reset), .start(start_c), .user_input(ui_c),
    .pattern(pat_c[0]), .round_num(rnd_c[0]), .level(lvl_c[0]), .busy(busy_c[0]), .game_over(go_c[0]));

  pattern_generator #(.LFSR_SEED(16'hFC00), .START_HOLD(1), .MIN_HOLD(1), .GAP_TICKS(1),
                      .NUM_ROUNDS(2)) dut_c1 (
    .counter10h(clk), .reset(reset), .start(start_c), .user_input(ui_c),
    .pattern(pat_c[1]), .round_num(rnd_c[1]), .level(lvl_c[1]), .busy(busy_c[1]), .game_over(go_c[1]));

  pattern_generator #(.LFSR_SEED(16'h03FF), .START_HOLD(1), .MIN_HOLD(1), .GAP_TICKS(1),
                      .NUM_ROUNDS(2)) dut_c2 (
    .counter10h(clk), .reset(reset), .start(start_c), .user_input(ui_c),
    .pattern(pat_c[2]), .round_num(rnd_c[2]), .level(lvl_c[2]), .busy(busy_c[2]), .game_over(go_c[2]));

  pattern_generator #(.LFSR_SEED(16'h0000), .START_HOLD(1), .MIN_HOLD(1), .GAP_TICKS(1),
                      .NUM_ROUNDS(2)) dut_c3 (
    .counter10h(clk), .reset(reset), .start(start_c), .user_input(ui_c),
    .pattern(pat_c[3]), .round_num(rnd_c[3]), .level(lvl_c[3]), .busy(busy_c[3]), .game_over(go_c[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ACE1 seed: round 1 uses s0[7:0]=E1; round 2 (edge 7) uses s6=B313 -> 13.
  logic [7:0] exp_a [12] = '{8'hE1, 8'hE1, 8'hE1, 8'hE1, 8'h00, 8'h00,
                             8'h13, 8'h13, 8'h13, 8'h13, 8'h00, 8'h00};
  int exp_hold [8] = '{6, 6, 5, 5, 4, 4, 4, 4};
  int exp_lvl  [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  logic [7:0] exp_c1 [4] = '{8'h55, 8'h01, 8'hFF, 8'h01};
  logic [7:0] exp_c2 [4] = '{8'h56, 8'h02, 8'h01, 8'h02};

  int  runs [8];
  int  lvls [8];
  int  gaps [8];
  int  nrun, cur, zc;
  bit  in_run;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    ui_a    = 8'h00; ui_b = 8'h00; ui_c = 8'h00;
    #12;
    check("rst_pattern", 32'(pat_a), 32'h0);
    check("rst_round",   32'(rnd_a), 32'h0);
    check("rst_level",   32'(lvl_a), 32'h0);
    check("rst_busy",    32'(busy_a), 32'h0);
    check("rst_gameover", 32'(go_a), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Full two-round game with no player input
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      check($sformatf("a_seq%0d", i), 32'(pat_a), 32'(exp_a[i]));
      if (i == 0) check("a_round1", 32'(rnd_a), 32'd1);
      if (i == 6) check("a_round2", 32'(rnd_a), 32'd2);
      if (i == 11) check("a_busy_blank", 32'(busy_a), 32'd1);
    end
    tick();
    check("a_done_go",    32'(go_a), 32'd1);
    check("a_done_round", 32'(rnd_a), 32'd2);
    check("a_done_busy",  32'(busy_a), 32'd0);
    check("a_done_pat",   32'(pat_a), 32'd0);

    // Restart from DONE (edge 14 uses s13=2B16 -> 16), then hold start in SHOW
    start_a = 1'b1;
    tick();
    check("a_restart_round", 32'(rnd_a), 32'd1);
    check("a_restart_go",    32'(go_a), 32'd0);
    check("a_restart_pat",   32'(pat_a), 32'h16);
    check("a_restart_busy",  32'(busy_a), 32'd1);
    tick();
    tick();
    check("a_start_ign_round", 32'(rnd_a), 32'd1);
    check("a_start_ign_pat",   32'(pat_a), 32'h16);

    // Reset between ticks mid-SHOW
    #2;
    reset = 1'b1;
    #1;
    check("a_midrst_pat",   32'(pat_a), 32'd0);
    check("a_midrst_round", 32'(rnd_a), 32'd0);
    check("a_midrst_busy",  32'(busy_a), 32'd0);
    check("a_midrst_level", 32'(lvl_a), 32'd0);
    start_a = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_post_rst_round", 32'(rnd_a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check($sformatf("a_post_rst_hold%0d", i), 32'(pat_a), 32'hE1);
    end
    tick();
    check("a_post_rst_blank", 32'(pat_a), 32'd0);

    // Player matches on the second SHOW tick
    pulse_reset();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_m_show1", 32'(pat_a), 32'hE1);
    tick();
    check("a_m_show2", 32'(pat_a), 32'hE1);
    ui_a = 8'hE1;
    tick();
    ui_a = 8'h00;
    check("a_m_blank1", 32'(pat_a), 32'd0);
    check("a_m_busy",   32'(busy_a), 32'd1);
    tick();
    check("a_m_blank2", 32'(pat_a), 32'd0);
    tick();
    check("a_m_next_pat",   32'(pat_a), 32'h4E);
    check("a_m_next_round", 32'(rnd_a), 32'd2);

    // Shrinking hold window over levels
    pulse_reset();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    nrun = 0; cur = 0; zc = 0; in_run = 1'b0;
    for (int i = 0; i < 8; i++) begin
      runs[i] = 0; lvls[i] = -1; gaps[i] = 0;
    end
    for (int t = 0; t < 200 && !go_b; t++) begin
      if (pat_b != 8'h00) begin
        if (!in_run) begin
          if (nrun > 0 && nrun <= 8) gaps[nrun-1] = zc;
          if (nrun < 8) lvls[nrun] = int'(lvl_b);
          in_run = 1'b1;
          cur = 0;
        end
        cur++;
      end else begin
        if (in_run) begin
          if (nrun < 8) runs[nrun] = cur;
          nrun++;
          in_run = 1'b0;
          zc = 0;
        end
        zc++;
      end
      tick();
    end
    check("b_gameover", 32'(go_b), 32'd1);
    check("b_nrounds",  32'(nrun), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b_hold%0d", i), 32'(runs[i]), 32'(exp_hold[i]));
      check($sformatf("b_level%0d", i), 32'(lvls[i]), 32'(exp_lvl[i]));
      if (i < 7) check($sformatf("b_gap%0d", i), 32'(gaps[i]), 32'd3);
    end
    check("b_final_level", 32'(lvl_b), 32'd3);
    check("b_final_round", 32'(rnd_b), 32'd8);

    // Collision / zero / wrap candidates
    pulse_reset();
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int k = 0; k < 4; k++)
      check($sformatf("c%0d_first", k), 32'(pat_c[k]), 32'(exp_c1[k]));
    tick();
    for (int k = 0; k < 4; k++)
      check($sformatf("c%0d_blank", k), 32'(pat_c[k]), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("c%0d_second", k), 32'(pat_c[k]), 32'(exp_c2[k]));
      check($sformatf("c%0d_round", k), 32'(rnd_c[k]), 32'd2);
    end
    tick();
    tick();
    for (int k = 0; k < 4; k++)
      check($sformatf("c%0d_done", k), 32'(go_c[k]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
